adder_operand_gen: RTL

Stimulus stage that drives the `a`/`b` operand inputs of the registered adder benchmark. It produces a programmable-length burst of pseudo-random operand pairs from two seeded LFSRs. It also tracks the adder's fixed pipeline latency, so downstream capture logic sees a `sum_valid` strobe aligned with each result and a single `done` pulse once the last result has emerged.

---
 rtl/adder_opgen_pkg.sv | 20 ++
 rtl/adder_opgen_lfsr.sv | 35 +++
 rtl/adder_operand_gen.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/adder_opgen_pkg.sv
// Shared types and constants for the adder operand generator: FSM encoding,
// LFSR feedback polynomial, word-mixing constant and carry-stress period.
package adder_opgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } opgen_state_e;

  localparam logic [31:0] LFSR_POLY           = 32'h80200003;
  localparam logic [31:0] WORD_MIX            = 32'h9E3779B9;
  localparam int          CARRY_STRESS_PERIOD = 8;

  // One Galois step: shift right, fold the polynomial in when a one falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/adder_opgen_lfsr.sv
// 32-bit Galois LFSR with seed load and step enable, expanded to an operand
// of WIDTH bits by XOR-ing each 32-bit word with a per-word mixing constant.
import adder_opgen_pkg::*;

module adder_opgen_lfsr #(
  parameter int          WIDTH = 95,
  parameter logic [31:0] SEED  = 32'h00000001
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] word
);

  localparam int          NWORDS  = (WIDTH + 31) / 32;
  localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] state;

  always_ff @(posedge clk) begin
    if (load) begin
      state <= SEED_NZ;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

  // The top word may be partial; only its low bits are kept.
  for (genvar i = 0; i < NWORDS; i++) begin : g_word
    localparam int          LEN = ((WIDTH - i * 32) < 32) ? (WIDTH - i * 32) : 32;
    localparam logic [31:0] MIX = 32'(i) * WORD_MIX;
    assign word[i*32 +: LEN] = LEN'(state ^ MIX);
  end

endmodule

// File: rtl/adder_operand_gen.sv
// Burst operand generator for the registered adder; tracks the adder latency
// to produce sum_valid and done. Optional macro: ADDER_OPGEN_CARRY_STRESS_EN.
import adder_opgen_pkg::*;

module adder_operand_gen #(
  parameter int          ADDER_WIDTH = 95,
  parameter int          PIPE_LAT    = 2,
  parameter logic [31:0] SEED_A      = 32'h00000001,
  parameter logic [31:0] SEED_B      = 32'h0000ACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            count,
  output logic [ADDER_WIDTH-1:0] a,
  output logic [ADDER_WIDTH-1:0] b,
  output logic                   op_valid,
  output logic                   sum_valid,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  // Handshake: there is no backpressure. start is a request honoured only in
  // IDLE; op_valid/sum_valid/done are one-cycle strobes with no ready.
  localparam logic [3:0] DRAIN_INIT = 4'(PIPE_LAT - 1);

  opgen_state_e            state;
  logic [15:0]             remaining;
  logic [3:0]              drain_cnt;
  logic [PIPE_LAT-1:0]     sum_dly;
  logic [ADDER_WIDTH-1:0]  word_a;
  logic [ADDER_WIDTH-1:0]  word_b;
  logic [ADDER_WIDTH-1:0]  a_next;
  logic [ADDER_WIDTH-1:0]  b_next;
  logic                    lfsr_step;

  assign lfsr_step = (state == ST_RUN);

  adder_opgen_lfsr #(.WIDTH(ADDER_WIDTH), .SEED(SEED_A)) u_lfsr_a (
    .clk  (clk),
    .load (reset),
    .step (lfsr_step),
    .word (word_a)
  );

  adder_opgen_lfsr #(.WIDTH(ADDER_WIDTH), .SEED(SEED_B)) u_lfsr_b (
    .clk  (clk),
    .load (reset),
    .step (lfsr_step),
    .word (word_b)
  );

`ifdef ADDER_OPGEN_CARRY_STRESS_EN
  localparam int IDX_W = $clog2(CARRY_STRESS_PERIOD);

  logic [IDX_W-1:0] stress_idx;
  logic             stress_now;

  always_ff @(posedge clk) begin
    if (reset || state != ST_RUN) begin
      stress_idx <= '0;
    end else begin
      stress_idx <= stress_idx + IDX_W'(1);
    end
  end

  // All-ones plus one ripples a carry through every bit of the adder.
  assign stress_now = (stress_idx == IDX_W'(CARRY_STRESS_PERIOD - 1));
  assign a_next     = stress_now ? '1 : word_a;
  assign b_next     = stress_now ? ADDER_WIDTH'(1) : word_b;
`else
  assign a_next = word_a;
  assign b_next = word_b;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      a         <= '0;
      b         <= '0;
      remaining <= '0;
      drain_cnt <= '0;
      op_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (count != 16'd0) begin
              remaining <= count;
              state     <= ST_RUN;
            end else begin
              drain_cnt <= 4'd0;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_RUN: begin
          op_valid  <= 1'b1;
          a         <= a_next;
          b         <= b_next;
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            drain_cnt <= DRAIN_INIT;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 4'd0) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Delay line mirroring the adder pipeline; cleared so reset leaves no strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_dly <= '0;
    end else begin
      sum_dly[0] <= op_valid;
      for (int i = 1; i < PIPE_LAT; i++) begin
        sum_dly[i] <= sum_dly[i-1];
      end
    end
  end

  assign sum_valid = sum_dly[PIPE_LAT-1];
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule
